// File: rtl/mac_sequencer.sv
// mac_sequencer: control sequencer for a time-multiplexed FIR multiply/accumulate datapath.
// Each input sample is processed in PHASES multiplier passes, followed by one final
// accumulate/round step. The sequencer also tracks coefficient loading and honours
// downstream backpressure.
// Optional feature: define MAC_SEQ_STATS_EN to build the 16-bit completed-sample counter.
// When the macro is undefined, samples_done is tied to 0.
module mac_sequencer #(
    parameter int PHASES = 4,
    parameter int SEL_W  = 2,
    parameter int NCOEF  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PushIn,
    input  logic              PushCoef,
    input  logic              fifo_empty,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  multiplier_mux_sel,
    output logic              partialProductAccumulate_valid,
    output logic              finalAccumulateRounding_en,
    output logic              fifoPullOut,
    output logic              coef_wr_en,
    output logic [ADDR_W-1:0] coef_wr_addr,
    output logic              coef_ready,
    output logic              coef_err,
    output logic              in_err,
    output logic [15:0]       samples_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ROUND = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(PHASES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCOEF - 1);

    state_t state;
    logic   can_pull;

    // A new sample may start only once a full coefficient set is present and data is waiting.
    assign can_pull = coef_ready && !fifo_empty;

    // Mealy strobes: these are decoded from the registered state and the current inputs.
    // They are forced low while reset is asserted, so every output drops immediately.
    always_comb begin
        coef_wr_en                     = 1'b0;
        fifoPullOut                    = 1'b0;
        partialProductAccumulate_valid = 1'b0;
        finalAccumulateRounding_en     = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    // A coefficient write takes priority over starting a sample.
                    if (PushCoef) begin
                        coef_wr_en = 1'b1;
                    end else if (can_pull) begin
                        fifoPullOut = 1'b1;
                    end
                end
                RUN: begin
                    partialProductAccumulate_valid = 1'b1;
                end
                ROUND: begin
                    // With out_ready low, stay in ROUND and keep every strobe low.
                    if (out_ready) begin
                        finalAccumulateRounding_en = 1'b1;
                        fifoPullOut                = can_pull;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencing FSM: holds the state and the multiplier phase.
    // The phase value is left unchanged outside RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            multiplier_mux_sel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!PushCoef && can_pull) begin
                        state              <= RUN;
                        multiplier_mux_sel <= '0;
                    end
                end
                RUN: begin
                    // fifo_empty is deliberately ignored here.
                    // The next pull decision is made only in ROUND.
                    if (multiplier_mux_sel == LAST_SEL) begin
                        state <= ROUND;
                    end else begin
                        multiplier_mux_sel <= multiplier_mux_sel + 1'b1;
                    end
                end
                ROUND: begin
                    if (out_ready) begin
                        if (can_pull) begin
                            state              <= RUN;
                            multiplier_mux_sel <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Coefficient load tracking: advance the write address and maintain the full-set flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_wr_addr <= '0;
            coef_ready   <= 1'b0;
        end else if (state == IDLE && PushCoef) begin
            // A write at address 0 begins a new set, so the old set is no longer complete.
            if (coef_wr_addr == '0) begin
                coef_ready <= 1'b0;
            end
            if (coef_wr_addr == LAST_ADDR) begin
                coef_wr_addr <= '0;
                coef_ready   <= 1'b1;
            end else begin
                coef_wr_addr <= coef_wr_addr + 1'b1;
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_err <= 1'b0;
            in_err   <= 1'b0;
        end else begin
            // coef_err: a coefficient arrived while a sample was in flight.
            if (PushCoef && state != IDLE) begin
                coef_err <= 1'b1;
            end
            // in_err: a sample was pushed while no complete coefficient set was loaded.
            if (PushIn && !coef_ready) begin
                in_err <= 1'b1;
            end
        end
    end

`ifdef MAC_SEQ_STATS_EN
    logic [15:0] sample_count;

    // Completed-sample counter: counts rounding strobes and wraps 65535 -> 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_count <= 16'd0;
        end else if (finalAccumulateRounding_en) begin
            sample_count <= sample_count + 16'd1;
        end
    end

    assign samples_done = sample_count;
`else
    assign samples_done = 16'd0;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed table, hand-written corner sequences and a randomized run
// checked against a transaction-level reference model.
module tb_mac_sequencer;

    localparam int P = 4;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        PushIn;
    logic        PushCoef;
    logic        fifo_empty;
    logic        out_ready;
    logic [1:0]  multiplier_mux_sel;
    logic        partialProductAccumulate_valid;
    logic        finalAccumulateRounding_en;
    logic        fifoPullOut;
    logic        coef_wr_en;
    logic [3:0]  coef_wr_addr;
    logic        coef_ready;
    logic        coef_err;
    logic        in_err;
    logic [15:0] samples_done;

    int n_checks = 0;
    int n_err    = 0;

    mac_sequencer #(.PHASES(P), .SEL_W(2), .NCOEF(N), .ADDR_W(4)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .PushIn                         (PushIn),
        .PushCoef                       (PushCoef),
        .fifo_empty                     (fifo_empty),
        .out_ready                      (out_ready),
        .multiplier_mux_sel             (multiplier_mux_sel),
        .partialProductAccumulate_valid (partialProductAccumulate_valid),
        .finalAccumulateRounding_en     (finalAccumulateRounding_en),
        .fifoPullOut                    (fifoPullOut),
        .coef_wr_en                     (coef_wr_en),
        .coef_wr_addr                   (coef_wr_addr),
        .coef_ready                     (coef_ready),
        .coef_err                       (coef_err),
        .in_err                         (in_err),
        .samples_done                   (samples_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pc, pi, fe, ordy;
        logic       pull, vld, rnd, wr;
        logic [1:0] sel;
        logic       cerr;
    } vec_t;

    vec_t tbl[16];

    // reference model state (transaction level)
    int m_left, m_rpend, m_last_sel, m_cnt, m_ready, m_cerr, m_ierr, m_samples;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pc, input logic pi, input logic fe, input logic ordy);
        PushCoef   = pc;
        PushIn     = pi;
        fifo_empty = fe;
        out_ready  = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".sel"},   32'(multiplier_mux_sel), 0);
        chk({name, ".vld"},   32'(partialProductAccumulate_valid), 0);
        chk({name, ".rnd"},   32'(finalAccumulateRounding_en), 0);
        chk({name, ".pull"},  32'(fifoPullOut), 0);
        chk({name, ".wr"},    32'(coef_wr_en), 0);
        chk({name, ".addr"},  32'(coef_wr_addr), 0);
        chk({name, ".ready"}, 32'(coef_ready), 0);
        chk({name, ".cerr"},  32'(coef_err), 0);
        chk({name, ".ierr"},  32'(in_err), 0);
        chk({name, ".done"},  32'(samples_done), 0);
    endtask

    // Assert reset with hostile inputs applied. Outputs must be zero throughout reset.
    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_now");
        @(negedge clk);
        chk_all_zero("rst_hold");
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
    endtask

    // Load 16 coefficients; the write address must run 0..15.
    task automatic load16();
        for (int i = 0; i < N; i++) begin
            PushCoef = 1'b1;
            @(negedge clk);
            chk("load.wr",   32'(coef_wr_en), 1);
            chk("load.addr", 32'(coef_wr_addr), 32'(i));
            chk("load.pull", 32'(fifoPullOut), 0);
            next_cycle();
        end
        PushCoef = 1'b0;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model.
    task automatic model_step();
        int idle, e_wr, e_pull, e_vld, e_rnd, e_sel;
        idle   = (m_left == 0 && m_rpend == 0);
        e_wr   = idle && PushCoef;
        e_pull = ((idle && !PushCoef) || (m_rpend && out_ready)) && m_ready && !fifo_empty;
        e_vld  = (m_left > 0);
        e_rnd  = m_rpend && out_ready;
        e_sel  = e_vld ? (P - m_left) : m_last_sel;
        chk("rnd.wr",    32'(coef_wr_en), 32'(e_wr));
        chk("rnd.pull",  32'(fifoPullOut), 32'(e_pull));
        chk("rnd.vld",   32'(partialProductAccumulate_valid), 32'(e_vld));
        chk("rnd.round", 32'(finalAccumulateRounding_en), 32'(e_rnd));
        chk("rnd.sel",   32'(multiplier_mux_sel), 32'(e_sel));
        chk("rnd.addr",  32'(coef_wr_addr), 32'(m_cnt));
        chk("rnd.ready", 32'(coef_ready), 32'(m_ready));
        chk("rnd.cerr",  32'(coef_err), 32'(m_cerr));
        chk("rnd.ierr",  32'(in_err), 32'(m_ierr));
`ifdef MAC_SEQ_STATS_EN
        chk("rnd.done",  32'(samples_done), 32'(m_samples));
`else
        chk("rnd.done",  32'(samples_done), 0);
`endif
        if (PushCoef && !idle) m_cerr = 1;
        if (PushIn && !m_ready) m_ierr = 1;
        if (e_rnd) m_samples = (m_samples + 1) % 65536;
        if (e_vld) m_last_sel = P - m_left;
        if (e_wr) begin
            if (m_cnt == 0) m_ready = 0;
            m_cnt++;
            if (m_cnt == N) begin
                m_cnt   = 0;
                m_ready = 1;
            end
        end
        if (e_pull) begin
            m_left  = P;
            m_rpend = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_rpend = 1;
        end else if (e_rnd) begin
            m_rpend = 0;
        end
    endtask

    initial begin
        // pc pi fe ordy | pull vld rnd wr sel cerr
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};

        drive(1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        #2;
        do_reset();

        // Full coefficient load: coef_ready rises one cycle after the 16th write.
        load16();
        @(negedge clk);
        chk("load.wrap_addr", 32'(coef_wr_addr), 0);
        chk("load.ready",     32'(coef_ready), 1);
        chk("load.idle_wr",   32'(coef_wr_en), 0);
        next_cycle();

        // Directed table: stall for 4 cycles in ROUND, then a back-to-back sample,
        // with a PushCoef during RUN.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].pc, tbl[i].pi, tbl[i].fe, tbl[i].ordy);
            @(negedge clk);
            chk($sformatf("tbl%0d.pull", i), 32'(fifoPullOut), 32'(tbl[i].pull));
            chk($sformatf("tbl%0d.vld", i),  32'(partialProductAccumulate_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d.rnd", i),  32'(finalAccumulateRounding_en), 32'(tbl[i].rnd));
            chk($sformatf("tbl%0d.wr", i),   32'(coef_wr_en), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d.sel", i),  32'(multiplier_mux_sel), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d.cerr", i), 32'(coef_err), 32'(tbl[i].cerr));
            next_cycle();
        end

        // Steady stream: one pull every 5 cycles, with phases 0..3.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, (i == 15), 1'b1);
            @(negedge clk);
            chk("steady.pull",  32'(fifoPullOut), 32'((i % 5 == 0) && (i < 15)));
            chk("steady.vld",   32'(partialProductAccumulate_valid), 32'(i % 5 != 0));
            chk("steady.round", 32'(finalAccumulateRounding_en), 32'((i % 5 == 0) && (i > 0)));
            chk("steady.sel",   32'(multiplier_mux_sel), (i % 5 != 0) ? 32'(i % 5 - 1) : 32'd3);
            next_cycle();
        end
        @(negedge clk);
`ifdef MAC_SEQ_STATS_EN
        chk("steady.done", 32'(samples_done), 5);
`else
        chk("steady.done", 32'(samples_done), 0);
`endif
        chk("steady.cerr_sticky", 32'(coef_err), 1);
        next_cycle();

        // Partial load of 10 coefficients: no pull is ever made, and PushIn sets in_err.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            chk("part.wr", 32'(coef_wr_en), 1);
            next_cycle();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            chk("part.pull",  32'(fifoPullOut), 0);
            chk("part.ready", 32'(coef_ready), 0);
            chk("part.ierr",  32'(in_err), 32'(k > 0));
            next_cycle();
        end

        // Asynchronous reset at phase 2 of a sample.
        do_reset();
        load16();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("mid.pull", 32'(fifoPullOut), 1);
        next_cycle();
        fifo_empty = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        chk("mid.sel_before", 32'(multiplier_mux_sel), 2);
        chk("mid.vld_before", 32'(partialProductAccumulate_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("mid.rst");
        @(negedge clk);
        chk_all_zero("mid.rst_neg");
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk("mid.nopull", 32'(fifoPullOut), 0);
            chk("mid.novld",  32'(partialProductAccumulate_valid), 0);
            next_cycle();
        end
        load16();
        @(negedge clk);
        chk("mid.reload_pull", 32'(fifoPullOut), 1);
        next_cycle();
        fifo_empty = 1'b1;
        for (int k = 0; k < 6; k++) next_cycle();

        // Randomized run against the reference model.
        do_reset();
        m_left = 0; m_rpend = 0; m_last_sel = 0; m_cnt = 0;
        m_ready = 0; m_cerr = 0; m_ierr = 0; m_samples = 0;
        for (int blk = 0; blk < 8; blk++) begin
            int pc_pct;
            pc_pct = (blk % 2 == 0) ? 40 : 2;
            for (int c = 0; c < 500; c++) begin
                drive($urandom_range(99) < pc_pct, $urandom_range(99) < 10,
                      $urandom_range(99) < 50, $urandom_range(99) < 70);
                @(negedge clk);
                model_step();
                next_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

- Parametrised successor to the FIR datapath control FSM.
- Sequences one input sample through `PHASES` time-multiplexed multiplier passes, then a final accumulate/round.
- Adds two things the earlier FSM lacks: coefficient-load tracking with gating, and downstream backpressure.
- Sits between the input sample FIFO, the coefficient RAM and the multiplier/accumulator datapath.

## Interface
Parameters:
- `PHASES`, 4: multiplier passes per sample; 2..2^`SEL_W`.
- `SEL_W`, 2: width of `multiplier_mux_sel`.
- `NCOEF`, 16: coefficients per full load; 2..2^`ADDR_W`.
- `ADDR_W`, 4: coefficient RAM address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `PushIn` input 1: sample push into the input FIFO; monitored only.
- `PushCoef` input 1: one coefficient presented this cycle.
- `fifo_empty` input 1: input FIFO empty.
- `out_ready` input 1: downstream accepts a rounded result.
- `multiplier_mux_sel` output `SEL_W`: current multiplier phase.
- `partialProductAccumulate_valid` output 1: partial product valid this cycle.
- `finalAccumulateRounding_en` output 1: final accumulate/round strobe.
- `fifoPullOut` output 1: pop the input FIFO.
- `coef_wr_en` output 1: coefficient RAM write enable.
- `coef_wr_addr` output `ADDR_W`: coefficient RAM write address.
- `coef_ready` output 1: complete coefficient set loaded.
- `coef_err` output 1: sticky; `PushCoef` arrived outside IDLE.
- `in_err` output 1: sticky; `PushIn` arrived while `coef_ready`=0.
- `samples_done` output 16: completed-sample count (see Configuration).

## Operation
States are IDLE, RUN and ROUND.

IDLE:
- If `PushCoef`: `coef_wr_en`=1 and write at `coef_wr_addr`.
  - The address increments each write.
  - A write at address 0 clears `coef_ready`.
  - A write at `NCOEF`-1 sets `coef_ready` next cycle and wraps the address to 0.
- Else if `coef_ready` && !`fifo_empty`: `fifoPullOut`=1, phase←0, go to RUN.
- `PushCoef` has priority over a pull in the same cycle.

RUN:
- `partialProductAccumulate_valid`=1 and `multiplier_mux_sel`=phase.
- Phase increments each cycle; at phase `PHASES`-1 go to ROUND.

ROUND:
- If `out_ready`=1: `finalAccumulateRounding_en`=1 for one cycle.
  - If `coef_ready` && !`fifo_empty`, also assert `fifoPullOut`, phase←0 and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- If `out_ready`=0: hold in ROUND with all strobes low.

Other rules:
- `PushCoef` in RUN or ROUND is ignored (no write) and sets `coef_err`.
- `PushIn` with `coef_ready`=0 sets `in_err`.
- Sticky flags clear only on reset.
- `multiplier_mux_sel` holds its last value outside RUN.
- Partial coefficient load: `coef_ready` stays 0 until `NCOEF` writes complete; samples are never pulled.

## Timing
- `fifoPullOut`, `coef_wr_en`, `partialProductAccumulate_valid` and `finalAccumulateRounding_en` are Mealy outputs: combinational from registered state and the current inputs.
- `coef_ready`, `coef_wr_addr`, `multiplier_mux_sel`, the flags and `samples_done` are registered.
- Pull at cycle t:
  - valid at t+1..t+`PHASES` with sel 0..`PHASES`-1;
  - rounding at t+`PHASES`+1 if `out_ready`, otherwise at the first cycle `out_ready`=1.
- Sustained throughput is one sample per `PHASES`+1 cycles.
- Reset, asynchronous including mid-operation:
  - state IDLE;
  - all outputs 0, `coef_wr_addr`=0, `multiplier_mux_sel`=0;
  - coefficients must be reloaded afterwards.
- `fifo_empty` is sampled only in IDLE and ROUND. It is ignored in RUN.

## Configuration
- `MAC_SEQ_STATS_EN` defined:
  - `samples_done` increments on every `finalAccumulateRounding_en`;
  - wraps 65535→0;
  - reset value 0.
- `MAC_SEQ_STATS_EN` undefined: `samples_done` is tied to 0 and no counter is built.

## Test plan
- Reset, then 16 `PushCoef` cycles -> `coef_wr_addr` runs 0..15 then wraps to 0; `coef_ready`=1 one cycle after the 16th write.
- `coef_ready`=1, `fifo_empty`=0, `out_ready`=1 steady -> `fifoPullOut` every 5 cycles; sel sequence 0,1,2,3; rounding once per sample; `samples_done`=3 after 3 samples (macro on).
- `out_ready` low for 4 cycles during ROUND -> rounding strobe delayed exactly 4 cycles; no pull and no valid meanwhile.
- `PushCoef` during RUN -> no `coef_wr_en`, `coef_err`=1 and stays 1; the sequence completes normally.
- Only 10 coefficients loaded, then `fifo_empty`=0 -> no `fifoPullOut`; `PushIn`=1 sets `in_err`.
- Reset asserted at phase 2 -> all outputs 0 immediately; `coef_ready`=0; after release no pull until 16 new coefficients are loaded.
